// File: rtl/cia_tod_seq_if.sv
// rtl/cia_tod_seq_if.sv - host request/response bundle for cia_tod_seq
//
// Groups the 32-bit host set/get handshake.
//   master (host side): drives host_req, host_op, host_alarm, host_wdata;
//                       receives host_rdata, host_ack, host_err, host_busy
//   slave  (sequencer): the mirror image
interface cia_tod_seq_if;
    logic        host_req;
    logic        host_op;
    logic        host_alarm;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic        host_err;
    logic        host_busy;

    modport master (
        output host_req, host_op, host_alarm, host_wdata,
        input  host_rdata, host_ack, host_err, host_busy
    );

    modport slave (
        input  host_req, host_op, host_alarm, host_wdata,
        output host_rdata, host_ack, host_err, host_busy
    );
endinterface

// File: rtl/cia_tod_seq.sv
// rtl/cia_tod_seq.sv - host access sequencer and arbiter for the CIA TOD register port
//
// Shares the cia_tod register port between the 6502 side (always wins, never
// stalled) and a host that sets/gets the whole time in one 32-bit request.
// Writes go out hours first (B, A, 9, 8); reads latch on hours (B) and
// unlatch on tenths (8), capturing the time on the tenths access.
//
// Optional feature macro: CIA_TOD_SEQ_RD_EN
//   defined   : full read path (R_HR/R_TS, cpu_latched tracking, restart)
//   undefined : read requests ack at once with host_err = 1, host_rdata = 0
//
// Ports
//   clk, res              clock, synchronous active-high reset
//   phi2_up, phi2_dn      one-clk PHI2 edge strobes
//   cpu_rd/we/addr/data   CPU register access, passed straight through
//   cpu_w_alarm           CRB7 alarm select
//   tod_*                 register port towards cia_tod
//   tod_regs              time as read from cia_tod ([31:24] tenths .. [7:0] hr)
//   host                  host request/response interface (slave modport)
module cia_tod_seq (
    input  logic        clk,
    input  logic        res,
    input  logic        phi2_up,
    input  logic        phi2_dn,
    input  logic        cpu_rd,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_w_alarm,
    output logic        tod_rd,
    output logic        tod_we,
    output logic [3:0]  tod_addr,
    output logic [7:0]  tod_data,
    output logic        tod_w_alarm,
    input  logic [31:0] tod_regs,
    cia_tod_seq_if.slave host
);

    localparam logic [3:0] A_TS  = 4'h8;
    localparam logic [3:0] A_SEC = 4'h9;
    localparam logic [3:0] A_MIN = 4'hA;
    localparam logic [3:0] A_HR  = 4'hB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_HR,
        S_W_MIN,
        S_W_SEC,
        S_W_TS,
        S_DONE
`ifdef CIA_TOD_SEQ_RD_EN
        ,
        S_R_HR,
        S_R_TS
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        alarm_q, alarm_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ack_q, ack_d;
    logic        phi2_hi;

    // Registered host step, decoded from the next state so it is in place
    // before the following PHI2-high phase begins.
    logic        step_rd_q, step_we_q, step_wal_q;
    logic [3:0]  step_addr_q;
    logic [7:0]  step_data_q;
    logic        step_rd_d, step_we_d, step_wal_d;
    logic [3:0]  step_addr_d;
    logic [7:0]  step_data_d;

    logic cpu_cyc;
    logic host_slot;
    logic abort;

    assign cpu_cyc   = cpu_rd | cpu_we;
    assign host_slot = phi2_dn & ~cpu_cyc;
    // A CPU write to the same TOD bank the host is writing invalidates the
    // host's multi-byte update.
    assign abort     = phi2_dn & cpu_we & (cpu_addr[3:2] == 2'b10)
                     & (cpu_w_alarm == alarm_q);

`ifdef CIA_TOD_SEQ_RD_EN
    logic latched_q, latched_d;
    logic cpu_rd_hr, cpu_rd_ts;

    assign cpu_rd_hr = phi2_dn & cpu_rd & ~cpu_w_alarm & (cpu_addr == A_HR);
    assign cpu_rd_ts = phi2_dn & cpu_rd & ~cpu_w_alarm & (cpu_addr == A_TS);
`else
    // tod_regs is only consumed by the read path.
    logic unused_tod_regs;
    assign unused_tod_regs = ^tod_regs;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_IDLE;
            alarm_q     <= 1'b0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            phi2_hi     <= 1'b0;
            step_rd_q   <= 1'b0;
            step_we_q   <= 1'b0;
            step_wal_q  <= 1'b0;
            step_addr_q <= 4'h0;
            step_data_q <= 8'h0;
`ifdef CIA_TOD_SEQ_RD_EN
            latched_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            alarm_q     <= alarm_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            step_rd_q   <= step_rd_d;
            step_we_q   <= step_we_d;
            step_wal_q  <= step_wal_d;
            step_addr_q <= step_addr_d;
            step_data_q <= step_data_d;
`ifdef CIA_TOD_SEQ_RD_EN
            latched_q   <= latched_d;
`endif
            if (phi2_up) begin
                phi2_hi <= 1'b1;
            end else if (phi2_dn) begin
                phi2_hi <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        alarm_d = alarm_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ack_d   = 1'b0;
`ifdef CIA_TOD_SEQ_RD_EN
        latched_d = latched_q;
        if (cpu_rd_hr) begin
            latched_d = 1'b1;
        end else if (cpu_rd_ts) begin
            latched_d = 1'b0;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (phi2_dn && host.host_req) begin
                    alarm_d = host.host_alarm;
                    wdata_d = host.host_wdata;
                    err_d   = 1'b0;
                    if (host.host_op) begin
                        state_d = S_W_HR;
                    end else begin
`ifdef CIA_TOD_SEQ_RD_EN
                        if (latched_q) begin
                            // CPU holds the latch: hand back its snapshot,
                            // flagged stale, without touching the port.
                            rdata_d = tod_regs;
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_R_HR;
                        end
`else
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_W_HR: begin
                if (abort) begin
                    err_d = 1'b1; state_d = S_DONE;
                end else if (host_slot) begin
                    state_d = S_W_MIN;
                end
            end
            S_W_MIN: begin
                if (abort) begin
                    err_d = 1'b1; state_d = S_DONE;
                end else if (host_slot) begin
                    state_d = S_W_SEC;
                end
            end
            S_W_SEC: begin
                if (abort) begin
                    err_d = 1'b1; state_d = S_DONE;
                end else if (host_slot) begin
                    state_d = S_W_TS;
                end
            end
            S_W_TS: begin
                if (abort) begin
                    err_d = 1'b1; state_d = S_DONE;
                end else if (host_slot) begin
                    state_d = S_DONE;
                end
            end
`ifdef CIA_TOD_SEQ_RD_EN
            S_R_HR: begin
                if (host_slot) begin
                    state_d = S_R_TS;
                end
            end
            S_R_TS: begin
                // The CPU unlatched our hours snapshot; start the read over.
                if (cpu_rd_ts) begin
                    state_d = S_R_HR;
                end else if (host_slot) begin
                    rdata_d = tod_regs;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_rd_d   = 1'b0;
        step_we_d   = 1'b0;
        step_wal_d  = 1'b0;
        step_addr_d = 4'h0;
        step_data_d = 8'h0;
        case (state_d)
            S_W_HR: begin
                step_we_d = 1'b1; step_addr_d = A_HR;  step_data_d = wdata_d[7:0];   step_wal_d = alarm_d;
            end
            S_W_MIN: begin
                step_we_d = 1'b1; step_addr_d = A_MIN; step_data_d = wdata_d[15:8];  step_wal_d = alarm_d;
            end
            S_W_SEC: begin
                step_we_d = 1'b1; step_addr_d = A_SEC; step_data_d = wdata_d[23:16]; step_wal_d = alarm_d;
            end
            S_W_TS: begin
                step_we_d = 1'b1; step_addr_d = A_TS;  step_data_d = wdata_d[31:24]; step_wal_d = alarm_d;
            end
`ifdef CIA_TOD_SEQ_RD_EN
            S_R_HR: begin
                step_rd_d = 1'b1; step_addr_d = A_HR;
            end
            S_R_TS: begin
                step_rd_d = 1'b1; step_addr_d = A_TS;
            end
`endif
            default: ;
        endcase
    end

    // CPU cycles pass through untouched; otherwise present the host step,
    // with its strobes limited to the PHI2-high phase.
    assign tod_rd      = cpu_cyc ? cpu_rd      : (phi2_hi & step_rd_q);
    assign tod_we      = cpu_cyc ? cpu_we      : (phi2_hi & step_we_q);
    assign tod_addr    = cpu_cyc ? cpu_addr    : step_addr_q;
    assign tod_data    = cpu_cyc ? cpu_data    : step_data_q;
    assign tod_w_alarm = cpu_cyc ? cpu_w_alarm : step_wal_q;

    assign host.host_rdata = rdata_q;
    assign host.host_ack   = ack_q;
    assign host.host_err   = err_q;
    assign host.host_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_cia_tod_seq.sv
// tb/tb_cia_tod_seq.sv - self-checking bench for cia_tod_seq
module tb_cia_tod_seq;

    logic        clk = 1'b0;
    logic        res;
    logic        phi2_up, phi2_dn;
    logic        cpu_rd, cpu_we, cpu_w_alarm;
    logic [3:0]  cpu_addr;
    logic [7:0]  cpu_data;
    logic        tod_rd, tod_we, tod_w_alarm;
    logic [3:0]  tod_addr;
    logic [7:0]  tod_data;
    logic [31:0] tod_regs;

    cia_tod_seq_if hif();

    cia_tod_seq dut (
        .clk         (clk),
        .res         (res),
        .phi2_up     (phi2_up),
        .phi2_dn     (phi2_dn),
        .cpu_rd      (cpu_rd),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_w_alarm (cpu_w_alarm),
        .tod_rd      (tod_rd),
        .tod_we      (tod_we),
        .tod_addr    (tod_addr),
        .tod_data    (tod_data),
        .tod_w_alarm (tod_w_alarm),
        .tod_regs    (tod_regs),
        .host        (hif)
    );

    always #5 clk = ~clk;

    // Stand-in for cia_tod: a live value that steps once per PHI2 cycle, with
    // the hours-read latch / tenths-read unlatch behaviour.
    localparam logic [31:0] LIVE_BASE = 32'h0030_5991;
    logic [31:0] live = LIVE_BASE;
    logic [31:0] snap = 32'h0;
    logic        lat  = 1'b0;

    always @(posedge clk) begin
        if (phi2_dn) begin
            live <= live + 32'd1;
            if (tod_rd && !tod_w_alarm && tod_addr == 4'hB) begin
                lat  <= 1'b1;
                snap <= live;
            end else if (tod_rd && !tod_w_alarm && tod_addr == 4'h8) begin
                lat <= 1'b0;
            end
        end
    end
    assign tod_regs = lat ? snap : live;

    typedef struct {
        logic       rd;
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        logic       wal;
    } acc_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [31:0] wdata;
        logic        alarm;
        logic [7:0]  mask;
        int          n;
    } wvec_t;

    acc_t        exp_acc[$];
    ack_t        exp_ack[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] exp_rdata = 32'h0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Every tod_* access taken at phi2_dn must match the next expected one.
    always @(negedge clk) begin
        if (phi2_dn && (tod_rd || tod_we)) begin
            if (exp_acc.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_access: rd=%b we=%b addr=%h data=%h, expected none",
                         tod_rd, tod_we, tod_addr, tod_data);
            end else begin
                acc_t e;
                e = exp_acc.pop_front();
                chk("acc_rdwe",  32'({tod_rd, tod_we}), 32'({e.rd, e.we}));
                chk("acc_addr",  32'(tod_addr), 32'(e.addr));
                if (e.we) chk("acc_data", 32'(tod_data), 32'(e.data));
                chk("acc_walarm", 32'(tod_w_alarm), 32'(e.wal));
            end
        end
        if (hif.host_ack) begin
            if (exp_ack.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: err=%b rdata=%h, expected none",
                         hif.host_err, hif.host_rdata);
            end else begin
                ack_t a;
                a = exp_ack.pop_front();
                chk("ack_err",   32'(hif.host_err), 32'(a.err));
                chk("ack_rdata", hif.host_rdata, a.rdata);
                chk("ack_cycle", 32'(cyc), 32'(a.cyc));
            end
        end
    end

    // One PHI2 cycle of 4 clks: up strobe, high phase, down strobe, low phase.
    task automatic do_cycle(input logic req, input logic rd, input logic we,
                            input logic [3:0] addr, input logic [7:0] data, input logic wal);
        acc_t e;
        hif.host_req = req;
        cpu_rd = rd; cpu_we = we; cpu_addr = addr; cpu_data = data; cpu_w_alarm = wal;
        if (rd || we) begin
            e = '{rd, we, addr, data, wal};
            exp_acc.push_back(e);
        end
        @(posedge clk); #1 phi2_up = 1'b1;
        @(posedge clk); #1 phi2_up = 1'b0;
        @(posedge clk); #1 phi2_dn = 1'b1;
        @(posedge clk); #1 phi2_dn = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    endtask

    function automatic void push_host(input logic rd, input logic [3:0] addr,
                                      input logic [7:0] data, input logic wal);
        acc_t e;
        e = '{rd, ~rd, addr, data, wal};
        exp_acc.push_back(e);
    endfunction

    function automatic void push_wbyte(input int bi, input logic [31:0] wd, input logic wal);
        case (bi)
            0:       push_host(1'b0, 4'hB, wd[7:0],   wal);
            1:       push_host(1'b0, 4'hA, wd[15:8],  wal);
            2:       push_host(1'b0, 4'h9, wd[23:16], wal);
            default: push_host(1'b0, 4'h8, wd[31:24], wal);
        endcase
    endfunction

    function automatic void push_ack(input logic err, input logic [31:0] rdata, input int c);
        ack_t a;
        a = '{err, rdata, c};
        exp_ack.push_back(a);
    endfunction

    task automatic start(input logic op, input logic al, input logic [31:0] wd);
        hif.host_op = op; hif.host_alarm = al; hif.host_wdata = wd;
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        chk("busy_after_accept", 32'(hif.host_busy), 32'd1);
    endtask

    // mask bit i set: PHI2 cycle i after acceptance carries a CPU read of addr i.
    task automatic run_write(input wvec_t v);
        int k, bi, i;
        k = cyc;
        push_ack(1'b0, exp_rdata, k + v.n + 1);
        start(1'b1, v.alarm, v.wdata);
        bi = 0;
        i  = 0;
        while (bi < 4 && i < 16) begin
            if (i < 8 && v.mask[i[2:0]]) begin
                do_cycle(1'b0, 1'b1, 1'b0, i[3:0], 8'h00, 1'b0);
            end else begin
                push_wbyte(bi, v.wdata, v.alarm);
                idle(1);
                bi++;
            end
            i++;
        end
        idle(2);
    endtask

    wvec_t tbl[4];

    initial begin
        int k;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        tbl[0] = '{32'h0030_5991, 1'b0, 8'b0000_0000, 4};
        tbl[1] = '{32'h0030_5991, 1'b0, 8'b0001_0101, 7};
        tbl[2] = '{32'h1234_5678, 1'b1, 8'b0000_0110, 6};
        tbl[3] = '{32'hA5C3_0F01, 1'b0, 8'b0000_1000, 5};

        res = 1'b1; phi2_up = 1'b0; phi2_dn = 1'b0;
        cpu_rd = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_data = 8'h00; cpu_w_alarm = 1'b0;
        hif.host_req = 1'b0; hif.host_op = 1'b0; hif.host_alarm = 1'b0; hif.host_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;

        chk("reset_busy",   32'(hif.host_busy), 32'd0);
        chk("reset_ack",    32'(hif.host_ack),  32'd0);
        chk("reset_err",    32'(hif.host_err),  32'd0);
        chk("reset_rdata",  hif.host_rdata,     32'd0);
        chk("reset_tod_rdwe", 32'({tod_rd, tod_we}), 32'd0);
        chk("reset_tod_addr", 32'(tod_addr), 32'd0);

        for (int t = 0; t < 4; t++) run_write(tbl[t]);

        // Alarm write, CPU writes seconds of the alarm bank after W_MIN: abort.
        k = cyc;
        push_ack(1'b1, exp_rdata, k + 4);
        start(1'b1, 1'b1, 32'h0045_3012);
        push_wbyte(0, 32'h0045_3012, 1'b1); idle(1);
        push_wbyte(1, 32'h0045_3012, 1'b1); idle(1);
        do_cycle(1'b0, 1'b0, 1'b1, 4'h9, 8'h77, 1'b1);
        idle(3);
        chk("abort_err_hold", 32'(hif.host_err), 32'd1);

        // Same, but the CPU writes the time bank: no abort, one cycle of delay.
        k = cyc;
        push_ack(1'b0, exp_rdata, k + 6);
        start(1'b1, 1'b1, 32'h0045_3012);
        push_wbyte(0, 32'h0045_3012, 1'b1); idle(1);
        push_wbyte(1, 32'h0045_3012, 1'b1); idle(1);
        do_cycle(1'b0, 1'b0, 1'b1, 4'h9, 8'h77, 1'b0);
        push_wbyte(2, 32'h0045_3012, 1'b1); idle(1);
        push_wbyte(3, 32'h0045_3012, 1'b1); idle(1);
        idle(2);

`ifdef CIA_TOD_SEQ_RD_EN
        // Uncontended read: snapshot taken at the hours access.
        k = cyc;
        exp_rdata = LIVE_BASE + 32'(k + 1);
        push_ack(1'b0, exp_rdata, k + 3);
        start(1'b0, 1'b0, 32'h0);
        push_host(1'b1, 4'hB, 8'h00, 1'b0); idle(1);
        push_host(1'b1, 4'h8, 8'h00, 1'b0); idle(1);
        idle(2);

        // CPU holds the latch: immediate stale ack with the CPU snapshot.
        k = cyc;
        do_cycle(1'b0, 1'b1, 1'b0, 4'hB, 8'h00, 1'b0);
        exp_rdata = LIVE_BASE + 32'(k);
        push_ack(1'b1, exp_rdata, k + 2);
        start(1'b0, 1'b0, 32'h0);
        idle(1);
        do_cycle(1'b0, 1'b1, 1'b0, 4'h8, 8'h00, 1'b0);
        idle(1);

        // CPU unlatches during R_TS: hours read is reissued.
        k = cyc;
        exp_rdata = LIVE_BASE + 32'(k + 3);
        push_ack(1'b0, exp_rdata, k + 5);
        start(1'b0, 1'b0, 32'h0);
        push_host(1'b1, 4'hB, 8'h00, 1'b0); idle(1);
        do_cycle(1'b0, 1'b1, 1'b0, 4'h8, 8'h00, 1'b0);
        push_host(1'b1, 4'hB, 8'h00, 1'b0); idle(1);
        push_host(1'b1, 4'h8, 8'h00, 1'b0); idle(1);
        idle(2);
`else
        // Read path absent: error ack one clk after acceptance, no port access.
        k = cyc;
        exp_rdata = 32'h0;
        push_ack(1'b1, 32'h0, k + 1);
        start(1'b0, 1'b0, 32'h0);
        idle(2);
`endif

        // Reset while in W_SEC: no ack, outputs back to reset values.
        start(1'b1, 1'b0, 32'h0123_4567);
        push_wbyte(0, 32'h0123_4567, 1'b0); idle(1);
        push_wbyte(1, 32'h0123_4567, 1'b0); idle(1);
        @(posedge clk); #1 res = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy",     32'(hif.host_busy), 32'd0);
        chk("midrst_ack",      32'(hif.host_ack),  32'd0);
        chk("midrst_err",      32'(hif.host_err),  32'd0);
        chk("midrst_rdata",    hif.host_rdata,     32'd0);
        chk("midrst_tod_rdwe", 32'({tod_rd, tod_we}), 32'd0);
        chk("midrst_tod_addr", 32'(tod_addr), 32'd0);
        chk("midrst_tod_data", 32'(tod_data), 32'd0);
        res = 1'b0;
        idle(3);

        chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
        chk("ack_queue_drained", 32'(exp_ack.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
